pipeline_trace_buffer: RTL and testbench

//  Synthesizable successor to the bench-side per-stage PC monitor.

---
 rtl/pipeline_trace_buffer_pkg.sv | 26 ++
 rtl/pipeline_trace_buffer_trace_ram.sv | 37 +++
 rtl/pipeline_trace_buffer.sv | 225 ++++++++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared encodings and entry sizing for the pipeline PC trace buffer.
package pipeline_trace_buffer_pkg;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'd0,
    MODE_STOPFULL = 2'd1,
    MODE_TRIG     = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PRE  = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // One stored entry: {stamp, vld[N-1:0], tag[N-1]..tag[0]}
  function automatic int unsigned entry_w(input int unsigned num_stages,
                                          input int unsigned tag_width,
                                          input int unsigned stamp_width);
    return stamp_width + num_stages * (1 + tag_width);
  endfunction

endpackage

// File: rtl/pipeline_trace_buffer_trace_ram.sv
// Trace storage: one write port, one registered read port; array is not reset.
module pipeline_trace_buffer_trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 41,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Read-before-write: a same-address write this cycle is not seen by the read.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Per-stage PC trace capture into a circular buffer with free-run,
// stop-on-full and triggered pre/post capture modes.
module pipeline_trace_buffer
  import pipeline_trace_buffer_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 5,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned TAG_WIDTH   = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STAMP_WIDTH = 16,
  parameter int unsigned POST_TRIG   = 8
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [NUM_STAGES*PC_WIDTH-1:0]                         stage_pc,
  input  logic [NUM_STAGES-1:0]                                  stage_vld,
  input  logic [1:0]                                             mode,
  input  logic                                                   start,
  input  logic                                                   stop,
  input  logic [PC_WIDTH-1:0]                                    trig_pc,
  input  logic                                                   rd_en,
  output logic [entry_w(NUM_STAGES, TAG_WIDTH, STAMP_WIDTH)-1:0] rd_data,
  output logic                                                   rd_valid,
  output logic [$clog2(DEPTH):0]                                 count,
  output logic                                                   overflow,
  output logic                                                   triggered,
  output logic                                                   done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = NUM_STAGES * (1 + TAG_WIDTH);
  localparam int unsigned EW = entry_w(NUM_STAGES, TAG_WIDTH, STAMP_WIDTH);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]           post_cnt_q, post_cnt_d;
  logic [CW-1:0]           count_q, count_d;
  logic [STAMP_WIDTH-1:0]  stamp_q, stamp_d;
  logic [SW-1:0]           last_s_q, last_s_d;
  logic                    first_q, first_d, fill_done_q, fill_done_d;
  logic                    overflow_q, overflow_d, triggered_q, triggered_d;
  logic                    done_q, done_d, rd_valid_q, rd_valid_d;

  logic [NUM_STAGES*TAG_WIDTH-1:0] tags_c;
  logic [SW-1:0]                   sample_c;
  logic capturing_c, cand_c, trig_hit_c, full_c, push_c, pop_c;
  logic unused_pc_c;

  always_comb begin
    tags_c = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++)
      tags_c[i*TAG_WIDTH +: TAG_WIDTH] = stage_pc[i*PC_WIDTH +: TAG_WIDTH];
    sample_c = {stage_vld, tags_c};
  end

  assign unused_pc_c = ^stage_pc;

  // After a stop-on-full completion, later candidates still count as drops.
  assign capturing_c = (state_q == ST_RUN) || (state_q == ST_PRE) || (state_q == ST_POST) ||
                       ((state_q == ST_DONE) && fill_done_q);
  assign cand_c      = capturing_c && (|stage_vld) && (first_q || (sample_c != last_s_q));
  assign trig_hit_c  = (state_q == ST_PRE) && stage_vld[0] && (stage_pc[PC_WIDTH-1:0] == trig_pc);
  assign full_c      = (count_q == CW'(DEPTH));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    post_cnt_d  = post_cnt_q;
    count_d     = count_q;
    stamp_d     = stamp_q + STAMP_WIDTH'(1);
    last_s_d    = last_s_q;
    first_d     = first_q;
    fill_done_d = fill_done_q;
    overflow_d  = overflow_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    rd_valid_d  = 1'b0;
    push_c      = 1'b0;
    pop_c       = 1'b0;

    if (start) begin
      mode_d      = (mode == 2'd3) ? MODE_FREE : mode_e'(mode);
      state_d     = (mode_d == MODE_TRIG) ? ST_PRE : ST_RUN;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      post_cnt_d  = '0;
      first_d     = 1'b1;
      fill_done_d = 1'b0;
      overflow_d  = 1'b0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      pop_c = rd_en && (count_q != '0);

      unique case (state_q)
        ST_RUN: begin
          if (cand_c) begin
            if ((mode_q == MODE_STOPFULL) && full_c && !pop_c) overflow_d = 1'b1;
            else                                               push_c     = 1'b1;
          end
        end
        ST_PRE:  push_c = trig_hit_c || cand_c;
        ST_POST: push_c = cand_c;
        ST_DONE: if (cand_c) overflow_d = 1'b1;
        default: ;
      endcase

      // A push into a full buffer with no pop evicts the oldest entry.
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        last_s_d = sample_c;
        first_d  = 1'b0;
        if (full_c && !pop_c) begin
          rd_ptr_d   = rd_ptr_q + AW'(1);
          overflow_d = 1'b1;
        end
      end
      if (pop_c) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_valid_d = 1'b1;
      end
      if (push_c && !pop_c && !full_c) count_d = count_q + CW'(1);
      else if (pop_c && !push_c)       count_d = count_q - CW'(1);

      unique case (state_q)
        ST_RUN: begin
          if (stop) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if ((mode_q == MODE_STOPFULL) && (count_d == CW'(DEPTH))) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            fill_done_d = 1'b1;
          end
        end
        ST_PRE: begin
          if (trig_hit_c) begin
            triggered_d = 1'b1;
            post_cnt_d  = '0;
            state_d     = ST_POST;
          end
          if (stop) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_POST: begin
          if (push_c) begin
            post_cnt_d = post_cnt_q + AW'(1);
            if (post_cnt_q == AW'(POST_TRIG - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
          if (stop) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_FREE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_cnt_q  <= '0;
      count_q     <= '0;
      stamp_q     <= '0;
      last_s_q    <= '0;
      first_q     <= 1'b0;
      fill_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      post_cnt_q  <= post_cnt_d;
      count_q     <= count_d;
      stamp_q     <= stamp_d;
      last_s_q    <= last_s_d;
      first_q     <= first_d;
      fill_done_q <= fill_done_d;
      overflow_q  <= overflow_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  pipeline_trace_buffer_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_trace_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push_c),
    .waddr (wr_ptr_q),
    .wdata ({stamp_q, sample_c}),
    .re    (pop_c),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign triggered = triggered_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Scenario tasks plus randomized traffic against a queue-based reference model.
module tb_pipeline_trace_buffer;

  localparam int unsigned NUM   = 5;
  localparam int unsigned PCW   = 32;
  localparam int unsigned TW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned STW   = 16;
  localparam int unsigned PT    = 8;
  localparam int unsigned SW    = NUM * (1 + TW);
  localparam int unsigned EW    = STW + SW;

  logic               clk;
  logic               rst;
  logic [NUM*PCW-1:0] stage_pc;
  logic [NUM-1:0]     stage_vld;
  logic [1:0]         mode;
  logic               start, stop, rd_en;
  logic [PCW-1:0]     trig_pc;
  logic [EW-1:0]      rd_data;
  logic               rd_valid;
  logic [4:0]         count;
  logic               overflow, triggered, done;

  int checks = 0;
  int errors = 0;

  // Reference model state: entries held as a plain queue, capture phase as a small int.
  logic [EW-1:0] mq[$];
  int            m_phase;   // 0 idle, 1 run, 2 pre-trigger, 3 post-trigger, 4 done
  int            m_mode;
  int            m_post;
  int            m_stamp;
  logic          m_first, m_full_stop, m_ovf, m_trg, m_done, m_rv;
  logic [SW-1:0] m_last;
  logic [EW-1:0] m_rd;

  pipeline_trace_buffer #(
    .NUM_STAGES (NUM), .PC_WIDTH (PCW), .TAG_WIDTH (TW),
    .DEPTH (DEPTH), .STAMP_WIDTH (STW), .POST_TRIG (PT)
  ) dut (
    .clk (clk), .rst (rst), .stage_pc (stage_pc), .stage_vld (stage_vld),
    .mode (mode), .start (start), .stop (stop), .trig_pc (trig_pc), .rd_en (rd_en),
    .rd_data (rd_data), .rd_valid (rd_valid), .count (count),
    .overflow (overflow), .triggered (triggered), .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM*PCW-1:0] pcs_seq(input logic [31:0] pc0);
    logic [NUM*PCW-1:0] v;
    for (int i = 0; i < int'(NUM); i++) v[i*PCW +: PCW] = pc0 - 32'(4 * i);
    return v;
  endfunction

  function automatic logic [SW-1:0] tags_of(input logic [31:0] pc0);
    logic [NUM*TW-1:0] t;
    logic [31:0]       p;
    for (int i = 0; i < int'(NUM); i++) begin
      p = pc0 - 32'(4 * i);
      t[i*TW +: TW] = p[TW-1:0];
    end
    return {5'h1f, t};
  endfunction

  function automatic logic [SW-1:0] cur_sample();
    logic [NUM*TW-1:0] t;
    for (int i = 0; i < int'(NUM); i++) t[i*TW +: TW] = stage_pc[i*PCW +: TW];
    return {stage_vld, t};
  endfunction

  function automatic void model_update();
    logic [SW-1:0] s;
    logic [EW-1:0] e;
    logic          cand, hit;
    int            ph0;
    if (!rst) begin
      mq.delete();
      m_phase = 0; m_mode = 0; m_post = 0; m_stamp = 0;
      m_first = 0; m_full_stop = 0; m_ovf = 0; m_trg = 0; m_done = 0; m_rv = 0;
      m_last = '0; m_rd = '0;
      return;
    end
    s    = cur_sample();
    e    = {16'(m_stamp), s};
    m_rv = 0;
    if (start) begin
      mq.delete();
      m_ovf = 0; m_trg = 0; m_done = 0; m_full_stop = 0; m_post = 0; m_first = 1;
      m_mode  = (mode == 2'd3) ? 0 : int'(mode);
      m_phase = (m_mode == 2) ? 2 : 1;
    end else begin
      ph0 = m_phase;
      if (rd_en && mq.size() > 0) begin
        m_rd = mq.pop_front();
        m_rv = 1;
      end
      cand = ((ph0 >= 1 && ph0 <= 3) || (ph0 == 4 && m_full_stop)) && (|stage_vld) &&
             (m_first || s != m_last);
      hit  = (ph0 == 2) && stage_vld[0] && (stage_pc[PCW-1:0] == trig_pc);
      if (ph0 == 4 && cand) m_ovf = 1;
      else if (hit || cand) begin
        if (m_mode == 1 && mq.size() == int'(DEPTH)) m_ovf = 1;
        else begin
          if (mq.size() == int'(DEPTH)) begin
            void'(mq.pop_front());
            m_ovf = 1;
          end
          mq.push_back(e);
          m_first = 0;
          m_last  = s;
          if (ph0 == 3) m_post++;
        end
      end
      if (hit) begin m_trg = 1; m_phase = 3; m_post = 0; end
      if (ph0 == 1 && m_mode == 1 && mq.size() == int'(DEPTH)) begin
        m_phase = 4; m_done = 1; m_full_stop = 1;
      end
      if (ph0 == 3 && m_post == int'(PT)) begin m_phase = 4; m_done = 1; end
      if (stop && ph0 >= 1 && ph0 <= 3) begin m_phase = 4; m_done = 1; m_full_stop = 0; end
    end
    m_stamp = (m_stamp + 1) % 65536;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    start = 1'b0;
    stop  = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (count !== 5'd0)     begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered got %0b exp 0", triggered); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid got %0b exp 0", rd_valid); end
    checks++; if (rd_data !== '0)     begin errors++; $display("FAIL reset_rd_data got %0h exp 0", rd_data); end
    rst = 1'b1;
  endtask

  task automatic test_free();
    logic [31:0] base;
    logic [15:0] prev;
    base = $urandom & 32'hFFFF_FFF0;
    mode = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
    start = 1'b1; stage_vld = '0;
    tick();
    for (int k = 0; k < 20; k++) begin
      stage_pc = pcs_seq(base + 32'(4 * k)); stage_vld = '1;
      tick();
      checks++; if (count !== 5'(mq.size())) begin errors++; $display("FAIL free_count k=%0d got %0d exp %0d", k, count, mq.size()); end
    end
    checks++; if (count !== 5'd16)   begin errors++; $display("FAIL free_full_count got %0d exp 16", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL free_overflow got %0b exp 1", overflow); end
    prev = '0;
    for (int k = 0; k < 16; k++) begin
      rd_en = 1'b1;
      tick();
      checks++; if (rd_valid !== 1'b1 || rd_data !== m_rd) begin errors++; $display("FAIL free_pop k=%0d got %0b/%0h exp 1/%0h", k, rd_valid, rd_data, m_rd); end
      if (k == 0) begin
        checks++; if (rd_data[SW-1:0] !== tags_of(base + 32'd16)) begin errors++; $display("FAIL free_oldest got %0h exp %0h", rd_data[SW-1:0], tags_of(base + 32'd16)); end
      end else begin
        checks++; if (rd_data[EW-1:SW] !== prev + 16'd1) begin errors++; $display("FAIL free_stamp k=%0d got %0h exp %0h", k, rd_data[EW-1:SW], prev + 16'd1); end
      end
      prev = rd_data[EW-1:SW];
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc;
    pc = $urandom;
    mode = 2'd0; start = 1'b1; stage_vld = '0;
    tick();
    stage_pc = pcs_seq(pc); stage_vld = '1;
    repeat (6) tick();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL stall_count got %0d exp 1", count); end
    stage_pc = pcs_seq(pc + 32'h100); stage_vld = '0;
    repeat (2) tick();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL bubble_count got %0d exp 1", count); end
    stage_pc = pcs_seq(pc); stage_vld = 5'b00110;
    tick();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL vld_change_count got %0d exp 2", count); end
  endtask

  task automatic test_stopfull();
    logic [31:0] base;
    base = $urandom & 32'hFFFF_FF00;
    mode = 2'd1; start = 1'b1; stage_vld = '0;
    tick();
    for (int k = 1; k <= 18; k++) begin
      stage_pc = pcs_seq(base + 32'(4 * k)); stage_vld = '1;
      tick();
      if (k == 15) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sf_done_early got %0b exp 0", done); end
      end
      if (k == 16) begin
        checks++; if (done !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL sf_done16 got done=%0b ovf=%0b exp 1/0", done, overflow); end
      end
    end
    checks++; if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL sf_drop got ovf=%0b cnt=%0d exp 1/16", overflow, count); end
    rd_en = 1'b1;
    tick();
    checks++; if (rd_data[SW-1:0] !== tags_of(base + 32'd4) || rd_data !== m_rd) begin errors++; $display("FAIL sf_first got %0h exp %0h", rd_data, m_rd); end
  endtask

  task automatic test_trig();
    trig_pc = 32'h40;
    mode = 2'd2; start = 1'b1; stage_vld = '0;
    tick();
    for (int k = 1; k <= 20; k++) begin
      stage_pc = pcs_seq(32'h40 + 32'(4 * k) - 32'd48); stage_vld = '1;
      tick();
      if (k == 11) begin
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL trig_early got %0b exp 0", triggered); end
      end
      if (k == 12) begin
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL trig_hit got %0b exp 1", triggered); end
      end
      if (k == 19) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL trig_done_early got %0b exp 0", done); end
      end
    end
    checks++; if (done !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL trig_done got done=%0b cnt=%0d exp 1/16", done, count); end
    for (int k = 0; k < 16; k++) begin
      rd_en = 1'b1;
      tick();
      checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL trig_pop k=%0d got %0h exp %0h", k, rd_data, m_rd); end
      if (k == 7) begin
        checks++; if (rd_data[SW-1:0] !== tags_of(32'h40)) begin errors++; $display("FAIL trig_entry_pos got %0h exp %0h", rd_data[SW-1:0], tags_of(32'h40)); end
      end
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0]   base;
    logic [EW-1:0] held;
    base = $urandom & 32'hFFFF_FF00;
    mode = 2'd0; start = 1'b1; stage_vld = '0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      stage_pc = pcs_seq(base + 32'(4 * k)); stage_vld = '1;
      tick();
    end
    checks++; if (count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL ppf_fill got cnt=%0d ovf=%0b exp 16/0", count, overflow); end
    stage_pc = pcs_seq(base + 32'd68); rd_en = 1'b1;
    tick();
    checks++; if (count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL ppf_both got cnt=%0d ovf=%0b exp 16/0", count, overflow); end
    checks++; if (rd_valid !== 1'b1 || rd_data[SW-1:0] !== tags_of(base + 32'd4)) begin errors++; $display("FAIL ppf_data got %0b/%0h exp 1/%0h", rd_valid, rd_data[SW-1:0], tags_of(base + 32'd4)); end
    for (int k = 0; k < 16; k++) begin
      rd_en = 1'b1;
      tick();
    end
    checks++; if (count !== 5'd0 || rd_data !== m_rd) begin errors++; $display("FAIL ppf_drain got cnt=%0d data=%0h exp 0/%0h", count, rd_data, m_rd); end
    held = rd_data;
    rd_en = 1'b1;
    tick();
    checks++; if (rd_valid !== 1'b0 || rd_data !== held) begin errors++; $display("FAIL ppf_empty_pop got %0b/%0h exp 0/%0h", rd_valid, rd_data, held); end
  endtask

  task automatic test_reset_mid_post();
    logic [31:0] base;
    trig_pc = 32'h40;
    mode = 2'd2; start = 1'b1; stage_vld = '0;
    tick();
    for (int k = 1; k <= 15; k++) begin
      stage_pc = pcs_seq(32'h40 + 32'(4 * k) - 32'd48); stage_vld = '1;
      tick();
    end
    checks++; if (triggered !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rmp_post got trg=%0b done=%0b exp 1/0", triggered, done); end
    rst = 1'b0;
    tick();
    checks++; if ({count, overflow, triggered, done, rd_valid} !== 9'd0 || rd_data !== '0) begin errors++; $display("FAIL rmp_reset got cnt=%0d ovf=%0b trg=%0b done=%0b rv=%0b data=%0h exp all 0", count, overflow, triggered, done, rd_valid, rd_data); end
    rst = 1'b1;
    base = $urandom & 32'hFFFF_FF00;
    mode = 2'd0; start = 1'b1; stage_vld = '0;
    tick();
    for (int k = 1; k <= 3; k++) begin
      stage_pc = pcs_seq(base + 32'(4 * k)); stage_vld = '1;
      tick();
    end
    checks++; if (count !== 5'd3 || done !== 1'b0) begin errors++; $display("FAIL rmp_resume got cnt=%0d done=%0b exp 3/0", count, done); end
    rd_en = 1'b1;
    tick();
    checks++; if (rd_data[SW-1:0] !== tags_of(base + 32'd4) || rd_data !== m_rd) begin errors++; $display("FAIL rmp_first got %0h exp %0h", rd_data, m_rd); end
  endtask

  task automatic test_random();
    logic [31:0] pc0;
    trig_pc = 32'h40;
    pc0     = 32'h38;
    mode = 2'($urandom_range(0, 3)); start = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) begin
        start = ($urandom_range(0, 99) < 3);
        mode  = 2'($urandom_range(0, 3));
      end
      stop  = ($urandom_range(0, 99) < 3);
      rd_en = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 1) == 1) pc0 = 32'h38 + 32'(4 * $urandom_range(0, 3));
      stage_pc  = pcs_seq(pc0);
      stage_vld = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      tick();
      checks++;
      if ({count, overflow, triggered, done, rd_valid, rd_data} !==
          {5'(mq.size()), m_ovf, m_trg, m_done, m_rv, m_rd}) begin
        errors++;
        $display("FAIL rand c=%0d got cnt=%0d ovf=%0b trg=%0b done=%0b rv=%0b data=%0h exp cnt=%0d ovf=%0b trg=%0b done=%0b rv=%0b data=%0h",
                 c, count, overflow, triggered, done, rd_valid, rd_data,
                 mq.size(), m_ovf, m_trg, m_done, m_rv, m_rd);
      end
    end
  endtask

  initial begin
    rst = 1'b0; stage_pc = '0; stage_vld = '0; mode = 2'd0;
    start = 1'b0; stop = 1'b0; rd_en = 1'b0; trig_pc = '0;
    test_reset();
    test_free();
    test_stall();
    test_stopfull();
    test_trig();
    test_push_pop_full();
    test_reset_mid_post();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
